// File: rtl/majority_pkg.sv
// -----------------------------------------------------------------------------
// majority_pkg
//   Shared definitions for the majority-vote arbiter:
//     slot_state_e : response slot state (EMPTY / FULL)
//     idw_of()     : width of a requester index for R requesters
//     vote_of()    : majority threshold rule (ones >= n/2, ties resolve to 1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package majority_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Index width for r requesters. Never less than one bit.
  function automatic int idw_of(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

  // Integer division on n means an even split is a tie, and a tie votes 1.
  function automatic logic vote_of(input int unsigned ones, input int unsigned n);
    return (ones >= (n / 2));
  endfunction

endpackage

// File: rtl/majority_n_bit.sv
// -----------------------------------------------------------------------------
// majority_n_bit
//   Purely combinational N-bit majority voter.
//   Ports:
//     i_vec [N-1:0] : vote vector
//     o_out         : 1 when popcount(i_vec) >= N/2
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module majority_n_bit
  import majority_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_vec,
  output logic         o_out
);

  localparam int CNTW = $clog2(N + 1);

  logic [CNTW-1:0] w_ones;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + CNTW'(i_vec[i]);
    end
  end

  assign o_out = vote_of(32'(w_ones), N);

endmodule

// File: rtl/majority_vote_arbiter.sv
// -----------------------------------------------------------------------------
// majority_vote_arbiter
//   R requesters share one majority voter. A round-robin arbiter picks at most
//   one request per cycle; the voted bit plus the requester index is held in a
//   single registered response slot with valid/ready handshake. A saturating
//   counter tracks accepted votes that resolved to 1.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     req_valid [R]         : per-requester request valid
//     req_data  [R*N]       : requester r vector at [r*N +: N]
//     req_ready [R]         : per-requester accept, one-hot or zero
//     rsp_valid/rsp_ready   : response slot handshake
//     rsp_out               : voted bit of the accepted vector
//     rsp_id    [IDW]       : requester that produced rsp_out
//     ones_count[CW]        : saturating count of votes equal to 1
//     clr_count             : synchronous clear of ones_count (beats increment)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module majority_vote_arbiter
  import majority_pkg::*;
#(
  parameter int N   = 16,
  parameter int R   = 4,
  parameter int CW  = 16,
  localparam int IDW = idw_of(R)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req_valid,
  input  logic [R*N-1:0]   req_data,
  output logic [R-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_out,
  output logic [IDW-1:0]   rsp_id,
  output logic [CW-1:0]    ones_count,
  input  logic             clr_count
);

  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  slot_state_e      r_state;
  logic             r_rsp_out;
  logic [IDW-1:0]   r_rsp_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_ones_count;

  logic [N-1:0]     w_req_vec [R];
  logic [N-1:0]     w_win_vec;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_any_req;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_vote;

  // Unpack the flattened request bus so the winner can be picked by index.
  for (genvar gi = 0; gi < R; gi++) begin : g_unpack
    assign w_req_vec[gi] = req_data[gi*N +: N];
  end

  // Round-robin search: start just after the last winner and wrap, so the
  // most recently served requester has lowest priority.
  always_comb begin
    w_any_req   = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= R; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % R;
      if (!w_any_req && req_valid[idx]) begin
        w_any_req   = 1'b1;
        w_grant_idx = IDW'(idx);
      end
    end
  end

  // rsp_ready only reaches req_ready through this term; the response
  // registers never see it combinationally.
  assign w_can_accept = (r_state == SLOT_EMPTY) || rsp_ready;
  assign w_accept     = w_any_req && w_can_accept;

  for (genvar gi = 0; gi < R; gi++) begin : g_ready
    assign req_ready[gi] = w_accept && (w_grant_idx == IDW'(gi));
  end

  assign w_win_vec = w_req_vec[w_grant_idx];

  majority_n_bit #(
    .N(N)
  ) u_voter (
    .i_vec(w_win_vec),
    .o_out(w_vote)
  );

  // Response slot FSM. An accept in FULL overwrites the slot (the old entry is
  // consumed in the same cycle, since accept implies rsp_ready there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SLOT_EMPTY;
      r_rsp_out <= 1'b0;
      r_rsp_id  <= '0;
      r_rr_ptr  <= IDW'(R - 1);
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (w_accept) begin
            r_state   <= SLOT_FULL;
            r_rsp_out <= w_vote;
            r_rsp_id  <= w_grant_idx;
            r_rr_ptr  <= w_grant_idx;
          end
        end
        SLOT_FULL: begin
          if (w_accept) begin
            r_state   <= SLOT_FULL;
            r_rsp_out <= w_vote;
            r_rsp_id  <= w_grant_idx;
            r_rr_ptr  <= w_grant_idx;
          end else if (rsp_ready) begin
            r_state   <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_count <= '0;
    end else if (clr_count) begin
      r_ones_count <= '0;
    end else if (w_accept && w_vote && (r_ones_count != COUNT_MAX)) begin
      r_ones_count <= r_ones_count + 1'b1;
    end
  end

  assign rsp_valid  = (r_state == SLOT_FULL);
  assign rsp_out    = r_rsp_out;
  assign rsp_id     = r_rsp_id;
  assign ones_count = r_ones_count;

endmodule
